// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes, FSM states, size decode.
// Latency: n/a (declarations only). Backpressure: n/a.
// Imported by mem_lsu and mem_lsu_ext.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        RESP
    } lsu_state_e;

    // Byte count of an access from funct3[1:0]; 11 is illegal and never reaches a beat.
    function automatic logic [2:0] lsu_size(input logic [1:0] size_code);
        case (size_code)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_ext.sv
// Load-data extension: picks B/H/W from captured bytes and sign- or zero-extends to 32 bits.
// Latency: combinational. Backpressure: none.
// Unknown funct3 yields 0.
module mem_lsu_ext
    import lsu_pkg::*;
(
    input  logic [31:0] cap_bytes,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    always_comb begin
        data = 32'h0;
        case (funct3)
            LB:      data = {{24{cap_bytes[7]}},  cap_bytes[7:0]};
            LH:      data = {{16{cap_bytes[15]}}, cap_bytes[15:0]};
            LW:      data = cap_bytes;
            LBU:     data = {24'h0, cap_bytes[7:0]};
            LHU:     data = {16'h0, cap_bytes[15:0]};
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// RV32I MEM-stage load/store unit: serialises B/H/W accesses onto an 8-bit DMEM port.
// Latency: store N+1, load N+2, error 1 cycle after acceptance (N = bytes).
// Backpressure: req_ready only in IDLE; busy covers acceptance..rsp; no rsp backpressure. Option: LSU_MISALIGN_TRAP_EN.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int A_WIDTH = 8
)
(
    input  logic               clk,
    input  logic               rst,

    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [2:0]         req_funct3,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,

    output logic               rsp_valid,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_err,
    output logic               busy,

    output logic               dmem_cs,
    output logic               dmem_wen_ren,
    output logic [A_WIDTH-1:0] dmem_addr,
    output logic [7:0]         dmem_wdata,
    input  logic [7:0]         dmem_rdata
);

    lsu_state_e   state;
    logic [1:0]   cnt;
    logic [2:0]   size_q;
    logic [2:0]   f3_q;
    logic         we_q;
    logic [31:0]  wdata_q;
    logic [31:0]  cap_q;

    logic [2:0]   req_size;
    logic         req_bad;
    logic         last_beat;
    logic [1:0]   cnt_nxt;
    logic [1:0]   cnt_prv;
    logic [31:0]  ext_data;
    logic         unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:A_WIDTH];

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    assign cnt_nxt   = cnt + 2'd1;
    assign cnt_prv   = cnt - 2'd1;
    assign last_beat = ({1'b0, cnt} == (size_q - 3'd1));

    always_comb begin
        req_size = lsu_size(req_funct3[1:0]);
        if (req_we) begin
            req_bad = !(req_funct3 inside {SB, SH, SW});
        end else begin
            req_bad = !(req_funct3 inside {LB, LH, LW, LBU, LHU});
        end
`ifdef LSU_MISALIGN_TRAP_EN
        if ((req_size == 3'd2 && req_addr[0]) ||
            (req_size == 3'd4 && req_addr[1:0] != 2'b00)) begin
            req_bad = 1'b1;
        end
`endif
    end

    mem_lsu_ext u_ext (
        .cap_bytes (cap_q),
        .funct3    (f3_q),
        .data      (ext_data)
    );

    // Load data is only presented on a clean load completion.
    assign rsp_rdata = (rsp_valid && !rsp_err && !we_q) ? ext_data : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 2'd0;
            size_q       <= 3'd0;
            f3_q         <= 3'd0;
            we_q         <= 1'b0;
            wdata_q      <= 32'h0;
            cap_q        <= 32'h0;
            dmem_cs      <= 1'b0;
            dmem_wen_ren <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= 8'h0;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        f3_q    <= req_funct3;
                        we_q    <= req_we;
                        wdata_q <= req_wdata;
                        size_q  <= req_size;
                        cnt     <= 2'd0;
                        cap_q   <= 32'h0;
                        if (req_bad) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            state        <= req_we ? WRITE : READ;
                            dmem_cs      <= 1'b1;
                            dmem_wen_ren <= req_we;
                            dmem_addr    <= req_addr[A_WIDTH-1:0];
                            dmem_wdata   <= req_we ? req_wdata[7:0] : 8'h0;
                        end
                    end
                end

                WRITE: begin
                    if (last_beat) begin
                        state        <= RESP;
                        dmem_cs      <= 1'b0;
                        dmem_wen_ren <= 1'b0;
                        dmem_addr    <= '0;
                        dmem_wdata   <= 8'h0;
                        rsp_valid    <= 1'b1;
                    end else begin
                        cnt        <= cnt_nxt;
                        dmem_addr  <= dmem_addr + A_WIDTH'(1);
                        dmem_wdata <= wdata_q[{cnt_nxt, 3'b000} +: 8];
                    end
                end

                READ: begin
                    // DMEM returns a byte one cycle after its read beat.
                    if (cnt != 2'd0) begin
                        cap_q[{cnt_prv, 3'b000} +: 8] <= dmem_rdata;
                    end
                    if (last_beat) begin
                        state     <= DRAIN;
                        dmem_cs   <= 1'b0;
                        dmem_addr <= '0;
                    end else begin
                        cnt       <= cnt_nxt;
                        dmem_addr <= dmem_addr + A_WIDTH'(1);
                    end
                end

                DRAIN: begin
                    cap_q[{cnt, 3'b000} +: 8] <= dmem_rdata;
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                end

                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed spec cases plus random traffic against a cycle-schedule model.
// Honours LSU_MISALIGN_TRAP_EN to match the build under test.
module tb_mem_lsu;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          busy;
    logic          dmem_cs;
    logic          dmem_wen_ren;
    logic [AW-1:0] dmem_addr;
    logic [7:0]    dmem_wdata;
    logic [7:0]    dmem_rdata = 8'h0;

    always #5 clk = ~clk;

    mem_lsu #(.A_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .dmem_cs      (dmem_cs),
        .dmem_wen_ren (dmem_wen_ren),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata)
    );

    // DMEM device and the model's shadow copy of what it should hold.
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];

    always @(posedge clk) begin
        if (dmem_cs && dmem_wen_ren)  mem[dmem_addr] <= dmem_wdata;
        if (dmem_cs && !dmem_wen_ren) dmem_rdata     <= mem[dmem_addr];
    end

    typedef struct packed {
        logic        ready;
        logic        busy;
        logic        cs;
        logic        wen;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic        rv;
        logic        rerr;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q;
    bit   exp_en = 1'b0;
    int   n_vec  = 0;
    int   n_err  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
        end
    endtask

    function automatic exp_t idle_exp();
        exp_t e;
        e       = '0;
        e.ready = 1'b1;
        return e;
    endfunction

    always @(negedge clk) begin
        if (exp_en) begin
            chk("req_ready",    32'(req_ready),    32'(exp_q.ready));
            chk("busy",         32'(busy),         32'(exp_q.busy));
            chk("dmem_cs",      32'(dmem_cs),      32'(exp_q.cs));
            chk("dmem_wen_ren", 32'(dmem_wen_ren), 32'(exp_q.wen));
            chk("dmem_addr",    32'(dmem_addr),    32'(exp_q.addr));
            chk("dmem_wdata",   32'(dmem_wdata),   32'(exp_q.wdata));
            chk("rsp_valid",    32'(rsp_valid),    32'(exp_q.rv));
            chk("rsp_err",      32'(rsp_err),      32'(exp_q.rerr));
            chk("rsp_rdata",    rsp_rdata,         exp_q.rdata);
        end
    end

    // Runs one request from its presentation cycle (0) to completion, or until reset is
    // pulsed in cycle abort_at (0 = never). Called at #1 after a rising edge.
    task automatic run_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int abort_at,
                           output logic [31:0] got_rd, output logic got_err);
        int          n;
        int          lat;
        bit          bad;
        bit          sgn;
        longint      val;
        logic [31:0] exp_rd;
        logic [7:0]  a;
        exp_t        e;

        n   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        bad = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00)) bad = 1'b1;
`endif
        sgn = !f3[2] && n < 4;
        val = 0;
        for (int i = 0; i < n; i++) begin
            a   = addr[7:0] + 8'(i);
            val = val + (longint'(ref_mem[a]) << (8 * i));
        end
        if (sgn && val >= (longint'(1) << (8 * n - 1))) val = val - (longint'(1) << (8 * n));
        exp_rd  = (we || bad) ? 32'h0 : val[31:0];
        lat     = bad ? 1 : (we ? n + 1 : n + 2);
        got_rd  = 32'h0;
        got_err = 1'b0;

        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        exp_q      = idle_exp();
        @(posedge clk); #1;

        for (int c = 1; c <= lat; c++) begin
            // Anything presented while busy must be ignored.
            req_valid  = 1'($urandom_range(0, 1));
            req_we     = 1'($urandom_range(0, 1));
            req_funct3 = 3'($urandom_range(0, 7));
            req_addr   = $urandom();
            req_wdata  = $urandom();
            e          = '0;
            e.busy     = 1'b1;
            if (!bad && c <= n) begin
                e.cs    = 1'b1;
                e.wen   = we;
                e.addr  = addr[7:0] + 8'(c - 1);
                e.wdata = we ? wd[8 * (c - 1) +: 8] : 8'h0;
                if (we) ref_mem[e.addr] = e.wdata;
            end
            if (c == lat) begin
                e.rv    = 1'b1;
                e.rerr  = bad;
                e.rdata = exp_rd;
            end
            exp_q = e;
            if (c == abort_at) rst = 1'b1;
            if (c == lat) begin
                @(negedge clk);
                got_rd  = rsp_rdata;
                got_err = rsp_err;
            end
            @(posedge clk); #1;
            if (c == abort_at) begin
                rst = 1'b0;
                break;
            end
        end
        req_valid = 1'b0;
        exp_q     = idle_exp();
    endtask

    task automatic idle_cycles(input int k);
        req_valid = 1'b0;
        exp_q     = idle_exp();
        repeat (k) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [2:0]  f3;
        bit          we;
        int          diffs;
        int          ab;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom());
            ref_mem[i] = mem[i];
        end
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        exp_q  = idle_exp();
        exp_en = 1'b1;
        idle_cycles(1);

        // SW with byte-serial little-endian writes.
        run_req(1'b1, 3'b010, 32'h0000_0003, 32'h4433_2211, 0, rd, er);
        chk("sw_err", 32'(er), 32'h0);
        chk("sw_mem", {mem[6], mem[5], mem[4], mem[3]}, 32'h4433_2211);

        // LB vs LBU of a byte with bit 7 set.
        mem[8'h10] = 8'h80; ref_mem[8'h10] = 8'h80;
        run_req(1'b0, 3'b000, 32'h0000_0010, 32'h0, 0, rd, er);
        chk("lb_data", rd, 32'hFFFF_FF80);
        run_req(1'b0, 3'b100, 32'h0000_0010, 32'h0, 0, rd, er);
        chk("lbu_data", rd, 32'h0000_0080);

        // LH across the top of the address space.
        mem[8'hFF] = 8'h34; ref_mem[8'hFF] = 8'h34;
        mem[8'h00] = 8'h92; ref_mem[8'h00] = 8'h92;
        run_req(1'b0, 3'b001, 32'h0000_00FF, 32'h0, 0, rd, er);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lh_wrap_err", 32'(er), 32'h1);
`else
        chk("lh_wrap_data", rd, 32'hFFFF_9234);
        chk("lh_wrap_err", 32'(er), 32'h0);
`endif

        // Illegal store size.
        run_req(1'b1, 3'b011, 32'h0000_0050, 32'hDEAD_BEEF, 0, rd, er);
        chk("ill_store_err", 32'(er), 32'h1);
        chk("ill_store_mem", 32'(mem[8'h50]), 32'(ref_mem[8'h50]));
        idle_cycles(1);

        // Reset in the middle of an LW, then a normal SB.
        run_req(1'b0, 3'b010, 32'h0000_0040, 32'h0, 2, rd, er);
        idle_cycles(1);
        run_req(1'b1, 3'b000, 32'h0000_0041, 32'h0000_00A5, 0, rd, er);
        chk("sb_after_rst", 32'(mem[8'h41]), 32'h0000_00A5);

        // Back-to-back SH then LHU.
        run_req(1'b1, 3'b001, 32'h0000_0020, 32'h0000_BEEF, 0, rd, er);
        run_req(1'b0, 3'b101, 32'h0000_0020, 32'h0, 0, rd, er);
        chk("b2b_lhu", rd, 32'h0000_BEEF);

        for (int t = 0; t < 300; t++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                f3 = 3'($urandom_range(0, 7));
            end else if (we) begin
                f3 = 3'($urandom_range(0, 2));
            end else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end
            ab = ($urandom_range(0, 29) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_req(we, f3, $urandom(), $urandom(), ab, rd, er);
            if (ab != 0 || $urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 2)));
        end

        exp_en = 1'b0;
        diffs  = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== ref_mem[i]) diffs++;
        end
        chk("mem_image", 32'(diffs), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit for the MEM stage of the RV32I pipeline. It accepts one load or store per handshake from the EX/MEM pipeline register and serialises it into byte accesses on the 8-bit-wide DMEM port (cs / wen_ren / addr / wdata / rdata). It returns sign- or zero-extended 32-bit load data, or store completion, to the pipeline. While an access is in flight it asserts `busy` so the hazard unit can stall the front of the pipeline.

## Interface
- `A_WIDTH`, 8, DMEM byte-address width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request (high only in IDLE).
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
- `req_addr`  in  32  byte address; only bits [A_WIDTH-1:0] are used.
- `req_wdata`  in  32  store data; the low N bytes are written.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  access rejected.
- `busy`  out  1  high from acceptance through the `rsp_valid` cycle.
- `dmem_cs`  out  1  DMEM chip select.
- `dmem_wen_ren`  out  1  1 = write, 0 = read.
- `dmem_addr`  out  A_WIDTH  DMEM byte address.
- `dmem_wdata`  out  8  DMEM write byte.
- `dmem_rdata`  in  8  DMEM read byte; valid the cycle after a read is sampled.

## Operation
- **States:** IDLE, WRITE, READ, DRAIN, RESP.
- **Acceptance:** a request is accepted when `req_valid && req_ready`. Request fields are latched at acceptance.
- **Size:** N = 1 for funct3[1:0] = 00, 2 for 01, 4 for 10.
- **Illegal funct3:** 011, 110 and 111 for loads, and any value ≥ 011 for stores, are illegal. The unit goes IDLE→RESP with `rsp_err` = 1 and makes no DMEM access.
- **Store (IDLE→WRITE):** on beat k = 0..N-1, drive `dmem_cs` = 1, `dmem_wen_ren` = 1, `dmem_addr` = addr+k, `dmem_wdata` = wdata[8k+7:8k] (little-endian). After the last beat, go to RESP.
- **Load (IDLE→READ):** on beat k, drive `dmem_cs` = 1, `dmem_wen_ren` = 0, `dmem_addr` = addr+k. Byte k-1 is captured from `dmem_rdata` at the end of beat k. After the last beat, go to DRAIN, which captures the final byte (`dmem_cs` = 0), then go to RESP.
- **RESP:** `rsp_valid` = 1 for one cycle, then return to IDLE.
- **Extension:** LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes all 32 bits.
- **Address arithmetic:** addr+k is computed modulo 2^A_WIDTH, so accesses wrap from 0xFF to 0x00 when A_WIDTH = 8.
- **Idle outputs:** outside WRITE/READ beats, `dmem_cs` = 0 and `dmem_wen_ren` = 0, and `dmem_addr`/`dmem_wdata` hold 0.
- **Idle-cycle handshake:** `req_valid` during a non-IDLE cycle is ignored and not queued. Upstream holds the request while `busy` is high.
- **Response:** there is no response back-pressure.

## Timing
- Acceptance edge = E0. Beats occupy cycles 1..N.
- Store: `rsp_valid` in cycle N+1 (2 / 3 / 5 cycles for B / H / W).
- Load: DRAIN in cycle N+1, `rsp_valid` in cycle N+2 (3 / 4 / 6 cycles).
- Error: `rsp_valid` in cycle 1.
- Back-to-back requests: the next request can be accepted in the cycle after RESP.
- Reset (synchronous, `rst` = 1): state goes to IDLE. All outputs are 0 except `req_ready` = 1. The captured-byte register is cleared.
- Reset mid-operation: the access is aborted on the reset edge. There are no further DMEM beats and no `rsp_valid`. DMEM contents already written stay written.

## Configuration
- `LSU_MISALIGN_TRAP_EN`
  - **Defined:** halfword with addr[0] ≠ 0, or word with addr[1:0] ≠ 0, takes IDLE→RESP with `rsp_err` = 1 and no DMEM access.
  - **Undefined:** misaligned accesses proceed byte-serially like aligned ones, and `rsp_err` is only raised for illegal funct3.

## Structure
- **Package `lsu_pkg`:** funct3 localparams (LB/LH/LW/LBU/LHU/SB/SH/SW), the state enum (IDLE, WRITE, READ, DRAIN, RESP), and the size-decode function.
- **Sub-module `mem_lsu_ext`:** purely combinational. It takes 4 captured bytes plus funct3 and produces the 32-bit extended result. It is instantiated once in `mem_lsu`.

## Test plan
- **SW:** addr 0x03, data 0x44332211 → writes 0x11/0x22/0x33/0x44 to 0x03..0x06 on cycles 1–4; `rsp_valid` in cycle 5 with `rsp_err` = 0.
- **LB vs LBU:** DMEM[0x10] = 0x80. LB → `rsp_rdata` 0xFFFFFF80. LBU → 0x00000080. `rsp_valid` in cycle 3.
- **LH wrap:** DMEM[0xFF] = 0x34, DMEM[0x00] = 0x92, LH at 0xFF.
  - Macro undefined: `dmem_addr` sequence 0xFF, 0x00; `rsp_rdata` 0xFFFF9234.
  - Macro defined: `rsp_err` = 1 in cycle 1, `dmem_cs` never asserted.
- **Illegal store funct3 011:** `rsp_valid` and `rsp_err` in cycle 1, `dmem_cs` never asserted, `req_ready` back high in cycle 2.
- **Reset mid-LW:** assert `rst` in cycle 2 → `dmem_cs` = 0 from cycle 3, no `rsp_valid`, `req_ready` = 1, next SB accepted normally.
- **Back-to-back:** SH at 0x20 (data 0xBEEF) then LHU at 0x20 → second request accepted the cycle after the first RESP; `rsp_rdata` 0x0000BEEF.
